flag_hazard_ctrl: RTL and testbench

- Controls the V/N/Z flag register in the pipelined core.
- Decodes the ALU op in ID and carries its flag-write class into EX. Drives change_en_Z and change_en_VN to the flag register for the op currently in EX.
- Resolves conditional branches in ID from the committed flags. Stalls ID when the op in EX is still producing a flag the branch needs.
- Keeps a saturating count of flag-hazard stall cycles.

---
 rtl/flag_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_flag_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// flag_hazard_ctrl
//
// Controls writes to the V/N/Z flag register and resolves conditional branches
// in ID from the committed flags. The ALU op in ID is decoded into a flag-write
// class, which moves into EX with the op. The EX class drives the flag-register
// write enables. A branch in ID that needs a flag still being produced by the
// op in EX stalls for one cycle. A saturating counter records the stall cycles.
//
// Ports:
//   clk           core clock; all state updates on the rising edge
//   clrn          asynchronous active-low reset
//   id_valid      ID holds a real instruction
//   id_aluc[3:0]  ALU control of the ID instruction
//   id_bcond[2:0] branch condition of the ID instruction (000 = not a branch)
//   stall_ext     external freeze; EX state holds
//   flush         squash the ID instruction
//   V, N, Z       committed flags from the flag register
//   change_en_Z   Z write enable for the op in EX
//   change_en_VN  V/N write enable for the op in EX
//   flag_stall    hold PC/IF/ID and insert a bubble into EX
//   br_valid      ID branch resolved this cycle
//   br_taken      branch outcome (0 unless br_valid)
//   stall_cnt     saturating count of flag_stall cycles (excluding frozen ones)
// -----------------------------------------------------------------------------
module flag_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             id_valid,
   input  logic [3:0]       id_aluc,
   input  logic [2:0]       id_bcond,
   input  logic             stall_ext,
   input  logic             flush,
   input  logic             V,
   input  logic             N,
   input  logic             Z,
   output logic             change_en_Z,
   output logic             change_en_VN,
   output logic             flag_stall,
   output logic             br_valid,
   output logic             br_taken,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             ex_valid_reg, ex_valid_next;
   logic             ex_wz_reg,    ex_wz_next;
   logic             ex_wvn_reg,   ex_wvn_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

   logic id_wz, id_wvn;
   logic need_z, need_vn;
   logic cond_true;
   logic id_br;

   // ALU op -> flag-write class
   always_comb begin
      id_wz  = 1'b0;
      id_wvn = 1'b0;
      case (id_aluc)
         4'b0000, 4'b0100: begin            // ADD, SUB
            id_wz  = 1'b1;
            id_wvn = 1'b1;
         end
         4'b0001, 4'b0010, 4'b0011,         // AND, XOR, SLL
         4'b0111, 4'b1111: begin            // SRL, SRA
            id_wz  = 1'b1;
         end
         default: ;                         // OR, LUI and the rest write nothing
      endcase
   end

   // Branch condition: which flags it reads, and its value on committed flags
   always_comb begin
      need_z    = 1'b0;
      need_vn   = 1'b0;
      cond_true = 1'b0;
      case (id_bcond)
         3'b001: begin need_z  = 1'b1; cond_true = Z;        end
         3'b010: begin need_z  = 1'b1; cond_true = ~Z;       end
         3'b011: begin need_vn = 1'b1; cond_true = N ^ V;    end
         3'b100: begin need_vn = 1'b1; cond_true = ~(N ^ V); end
         3'b101: begin need_vn = 1'b1; cond_true = V;        end
         3'b110: begin need_vn = 1'b1; cond_true = ~V;       end
         3'b111: begin                 cond_true = 1'b1;     end
         default: ;
      endcase
   end

   assign id_br = id_valid & ~flush & (id_bcond != 3'b000);

   // The EX writer commits in the low phase of its cycle, so one bubble is
   // always enough for the flags to be current at V/N/Z.
   assign flag_stall   = id_br & ex_valid_reg &
                         ((need_z & ex_wz_reg) | (need_vn & ex_wvn_reg));
   assign br_valid     = id_br & ~flag_stall & ~stall_ext;
   assign br_taken     = br_valid & cond_true;
   assign change_en_Z  = ex_valid_reg & ex_wz_reg;
   assign change_en_VN = ex_valid_reg & ex_wvn_reg;
   assign stall_cnt    = stall_cnt_reg;

   always_comb begin
      ex_valid_next  = ex_valid_reg;
      ex_wz_next     = ex_wz_reg;
      ex_wvn_next    = ex_wvn_reg;
      stall_cnt_next = stall_cnt_reg;
      if (!stall_ext) begin
         if (flush || flag_stall || !id_valid) begin
            ex_valid_next = 1'b0;
            ex_wz_next    = 1'b0;
            ex_wvn_next   = 1'b0;
         end else begin
            ex_valid_next = 1'b1;
            ex_wz_next    = id_wz;
            ex_wvn_next   = id_wvn;
         end
         // Frozen stall cycles are not counted; they belong to the external wait.
         if (flag_stall && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_next = stall_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ex_valid_reg  <= 1'b0;
         ex_wz_reg     <= 1'b0;
         ex_wvn_reg    <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         ex_valid_reg  <= ex_valid_next;
         ex_wz_reg     <= ex_wz_next;
         ex_wvn_reg    <= ex_wvn_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_hazard_ctrl
//
// Scoreboard bench for flag_hazard_ctrl. Two instances share the stimulus: one
// with the default counter width and one with CNT_W=2 to reach saturation.
// -----------------------------------------------------------------------------
module tb_flag_hazard_ctrl;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;

   logic clk = 1'b0;
   logic clrn;
   logic id_valid;
   logic [3:0] id_aluc;
   logic [2:0] id_bcond;
   logic stall_ext, flush, V, N, Z;
   logic change_en_Z, change_en_VN, flag_stall, br_valid, br_taken;
   logic [15:0] stall_cnt;
   logic s_cz, s_cvn, s_fs, s_bv, s_bt;
   logic [1:0] stall_cnt2;

   always #5 clk = ~clk;

   flag_hazard_ctrl dut (
      .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_aluc(id_aluc),
      .id_bcond(id_bcond), .stall_ext(stall_ext), .flush(flush),
      .V(V), .N(N), .Z(Z),
      .change_en_Z(change_en_Z), .change_en_VN(change_en_VN),
      .flag_stall(flag_stall), .br_valid(br_valid), .br_taken(br_taken),
      .stall_cnt(stall_cnt)
   );

   flag_hazard_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_aluc(id_aluc),
      .id_bcond(id_bcond), .stall_ext(stall_ext), .flush(flush),
      .V(V), .N(N), .Z(Z),
      .change_en_Z(s_cz), .change_en_VN(s_cvn),
      .flag_stall(s_fs), .br_valid(s_bv), .br_taken(s_bt),
      .stall_cnt(stall_cnt2)
   );

   typedef struct packed {
      logic        cz;
      logic        cvn;
      logic        fs;
      logic        bv;
      logic        bt;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state
   logic        m_valid, m_wz, m_wvn;
   int          m_cnt, m_cnt2;
   logic [15:0] wz_tab  = 16'h809F;   // codes 0,1,2,3,4,7,15
   logic [15:0] wvn_tab = 16'h0011;   // codes 0,4

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_wz = 1'b0; m_wvn = 1'b0;
      m_cnt = 0; m_cnt2 = 0;
   endtask

   // One cycle: drive at posedge+1, push expectation, compare at negedge,
   // advance model, return at next posedge+1.
   task automatic drive(input logic vld, input logic [3:0] op, input logic [2:0] bc,
                        input logic se, input logic fl,
                        input logic v, input logic n, input logic z);
      exp_t e, got;
      logic nz, nvn, br, tk;
      id_valid = vld; id_aluc = op; id_bcond = bc;
      stall_ext = se; flush = fl; V = v; N = n; Z = z;
      nz  = (bc == 3'd1) || (bc == 3'd2);
      nvn = (bc >= 3'd3) && (bc <= 3'd6);
      br  = vld && !fl && (bc != 3'd0);
      case (bc)
         3'd1: tk = z;
         3'd2: tk = !z;
         3'd3: tk = n ^ v;
         3'd4: tk = !(n ^ v);
         3'd5: tk = v;
         3'd6: tk = !v;
         3'd7: tk = 1'b1;
         default: tk = 1'b0;
      endcase
      e.cz   = m_valid && m_wz;
      e.cvn  = m_valid && m_wvn;
      e.fs   = br && m_valid && ((nz && m_wz) || (nvn && m_wvn));
      e.bv   = br && !e.fs && !se;
      e.bt   = e.bv && tk;
      e.cnt  = 16'(m_cnt);
      e.cnt2 = 2'(m_cnt2);
      exp_q.push_back(e);

      @(negedge clk);
      got = exp_q.pop_front();
      check("change_en_Z",  {31'd0, change_en_Z},  {31'd0, got.cz});
      check("change_en_VN", {31'd0, change_en_VN}, {31'd0, got.cvn});
      check("flag_stall",   {31'd0, flag_stall},   {31'd0, got.fs});
      check("br_valid",     {31'd0, br_valid},     {31'd0, got.bv});
      check("br_taken",     {31'd0, br_taken},     {31'd0, got.bt});
      check("stall_cnt",    {16'd0, stall_cnt},    {16'd0, got.cnt});
      check("stall_cnt_w2", {30'd0, stall_cnt2},   {30'd0, got.cnt2});
      $display("cyc %0d v=%0b op=%h bc=%0d se=%0b fl=%0b VNZ=%0b%0b%0b -> cz=%0b cvn=%0b fs=%0b bv=%0b bt=%0b cnt=%0d cnt2=%0d",
               cyc, vld, op, bc, se, fl, v, n, z, change_en_Z, change_en_VN,
               flag_stall, br_valid, br_taken, stall_cnt, stall_cnt2);

      if (!se) begin
         if (fl || e.fs || !vld) begin
            m_valid = 1'b0; m_wz = 1'b0; m_wvn = 1'b0;
         end else begin
            m_valid = 1'b1; m_wz = wz_tab[op]; m_wvn = wvn_tab[op];
         end
         if (e.fs) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Assert reset mid-cycle with the current EX state and check outputs drop
   // before the next clock edge.
   task automatic async_reset_probe(input logic [2:0] bc);
      id_valid = 1'b1; id_aluc = OP_OR; id_bcond = bc;
      stall_ext = 1'b0; flush = 1'b0; V = 1'b0; N = 1'b0; Z = 1'b0;
      #2;
      if (bc == 3'd0) check("pre_rst_cz", {31'd0, change_en_Z}, 32'd1);
      else            check("pre_rst_fs", {31'd0, flag_stall}, 32'd1);
      clrn = 1'b0;
      #1;
      check("rst_cz",  {31'd0, change_en_Z},  32'd0);
      check("rst_cvn", {31'd0, change_en_VN}, 32'd0);
      check("rst_fs",  {31'd0, flag_stall},   32'd0);
      check("rst_cnt", {16'd0, stall_cnt},    32'd0);
      if (bc == 3'd0) begin
         check("rst_bv", {31'd0, br_valid}, 32'd0);
         check("rst_bt", {31'd0, br_taken}, 32'd0);
      end
      $display("cyc %0d async reset probe bc=%0d -> cz=%0b fs=%0b cnt=%0d",
               cyc, bc, change_en_Z, flag_stall, stall_cnt);
      model_reset();
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      clrn = 1'b0;
      id_valid = 1'b0; id_aluc = 4'd0; id_bcond = 3'd0;
      stall_ext = 1'b0; flush = 1'b0; V = 1'b0; N = 1'b0; Z = 1'b0;
      model_reset();
      #2;
      check("reset_cz",  {31'd0, change_en_Z},  32'd0);
      check("reset_cvn", {31'd0, change_en_VN}, 32'd0);
      check("reset_fs",  {31'd0, flag_stall},   32'd0);
      check("reset_bv",  {31'd0, br_valid},     32'd0);
      check("reset_bt",  {31'd0, br_taken},     32'd0);
      check("reset_cnt", {16'd0, stall_cnt},    32'd0);
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);
      #1;

      // Reset while a SUB sits in EX, then reset in the middle of a stall
      drive(1, OP_SUB, 3'd0, 0, 0, 0, 0, 0);
      async_reset_probe(3'd0);
      drive(1, OP_ADD, 3'd0, 0, 0, 0, 0, 0);
      async_reset_probe(3'd1);

      // SUB then non-branches: both enables for one cycle; OR writes nothing
      drive(1, OP_SUB, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd0, 0, 0, 0, 0, 0);

      // XOR in EX, BLT in ID: no stall, V=1 N=0 -> taken
      drive(1, OP_XOR, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd3, 0, 0, 1, 0, 0);

      // ADD in EX, BEQ in ID: one stall, then resolves taken with Z=1
      drive(1, OP_ADD, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd1, 0, 0, 0, 0, 0);
      check("plan_cnt_after_stall", {16'd0, stall_cnt}, 32'd1);
      drive(1, OP_OR,  3'd1, 0, 0, 0, 0, 1);

      // Hazard frozen by stall_ext for 3 cycles, then bubble, then resolve
      drive(1, OP_ADD, 3'd0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, OP_OR, 3'd1, 1, 0, 0, 0, 0);
      check("plan_cnt_frozen", {16'd0, stall_cnt}, 32'd1);
      drive(1, OP_OR, 3'd1, 0, 0, 0, 0, 0);
      drive(1, OP_OR, 3'd1, 0, 0, 0, 0, 0);

      // Flushed BNE behind SLL: no stall, no branch, bubble into EX
      drive(1, OP_SLL, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd2, 0, 1, 0, 0, 0);
      drive(1, OP_OR,  3'd0, 0, 0, 0, 0, 0);

      // Non-branch behind a writer never stalls; unconditional never stalls
      drive(1, OP_ADD, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_SUB, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd7, 0, 0, 0, 0, 0);

      // flush with stall_ext: EX holds ADD, no branch resolves
      drive(1, OP_ADD, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd1, 1, 1, 0, 0, 0);
      drive(1, OP_OR,  3'd0, 0, 0, 0, 0, 0);

      // Z-only writer does not block a VN branch; VN writer blocks BGE
      drive(1, OP_AND, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd5, 0, 0, 1, 0, 0);
      drive(1, OP_SUB, 3'd0, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd4, 0, 0, 0, 0, 0);
      drive(1, OP_OR,  3'd4, 0, 0, 0, 1, 0);

      // More stalls to saturate the 2-bit counter
      for (int i = 0; i < 3; i++) begin
         drive(1, OP_ADD, 3'd0, 0, 0, 0, 0, 0);
         drive(1, OP_OR,  3'd6, 0, 0, 0, 0, 0);
      end
      check("plan_cnt_total", {16'd0, stall_cnt},  32'd6);
      check("plan_cnt_sat",   {30'd0, stall_cnt2}, 32'd3);

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
